// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic controller.
//   ctrl_state_t : controller FSM state encoding
//   DW_DEF/CW_DEF: default operand / accumulator widths
//   IDX00..IDX11 : element slots inside the packed 2x2 matrices
//                  (slot k occupies bits [k*W +: W], so IDX00 sits in the MSBs)
package systolic_pkg;

  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;

  localparam int IDX00 = 3;
  localparam int IDX01 = 2;
  localparam int IDX10 = 1;
  localparam int IDX11 = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED0 = 3'd1,
    FEED1 = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/systolic_2x2_ctrl.sv
// Operand sequencer / result collector for the 2x2 output-stationary MAC array.
// Takes one A,B job, feeds two array cycles, waits PE_LAT cycles, then returns
// C = A x B as (accumulator after - accumulator before), since the PE
// accumulators are never cleared.
//
// State table
//   state | meaning
//   IDLE  | ready for a job, base snapshot taken on accept
//   FEED0 | array gets column 0 of A and row 0 of B
//   FEED1 | array gets column 1 of A and row 1 of B
//   DRAIN | wait PE_LAT cycles for the accumulators to settle
//   DONE  | result valid and held until consumer takes it
//
// Ports
//   i_clk, i_rst_n          clock, async active-low reset (shared with array)
//   i_in_valid/o_in_ready   job handshake, i_a_mat/i_b_mat packed operands
//   o_arr_en, o_arr_a0/a1/b0/b1  array drive
//   i_arr_c00..c11          array accumulators
//   o_out_valid/i_out_ready result handshake, o_c_res packed result
//   o_busy                  high outside IDLE
module systolic_2x2_ctrl
  import systolic_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int CW     = CW_DEF,
  parameter int PE_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [4*DW-1:0] i_a_mat,
  input  logic [4*DW-1:0] i_b_mat,
  output logic            o_arr_en,
  output logic [DW-1:0]   o_arr_a0,
  output logic [DW-1:0]   o_arr_a1,
  output logic [DW-1:0]   o_arr_b0,
  output logic [DW-1:0]   o_arr_b1,
  input  logic [CW-1:0]   i_arr_c00,
  input  logic [CW-1:0]   i_arr_c01,
  input  logic [CW-1:0]   i_arr_c10,
  input  logic [CW-1:0]   i_arr_c11,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [4*CW-1:0] o_c_res,
  output logic            o_busy
);

  localparam int CNTW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  ctrl_state_t     r_state;
  logic [4*DW-1:0] r_a;
  logic [4*DW-1:0] r_b;
  logic [4*CW-1:0] r_base;
  logic [4*CW-1:0] r_c_res;
  logic [CNTW-1:0] r_cnt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_base      <= '0;
      r_c_res     <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a        <= i_a_mat;
            r_b        <= i_b_mat;
            r_base     <= {i_arr_c00, i_arr_c01, i_arr_c10, i_arr_c11};
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= FEED0;
          end
        end
        FEED0: r_state <= FEED1;
        FEED1: begin
          r_cnt   <= CNTW'(PE_LAT - 1);
          r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_cnt == '0) begin
            // Subtraction wraps mod 2^CW, so accumulator wrap cancels out.
            r_c_res[IDX00*CW +: CW] <= i_arr_c00 - r_base[IDX00*CW +: CW];
            r_c_res[IDX01*CW +: CW] <= i_arr_c01 - r_base[IDX01*CW +: CW];
            r_c_res[IDX10*CW +: CW] <= i_arr_c10 - r_base[IDX10*CW +: CW];
            r_c_res[IDX11*CW +: CW] <= i_arr_c11 - r_base[IDX11*CW +: CW];
            r_out_valid             <= 1'b1;
            r_state                 <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Array drive depends only on state and latched operands, never on inputs.
  always_comb begin
    o_arr_en = 1'b0;
    o_arr_a0 = '0;
    o_arr_a1 = '0;
    o_arr_b0 = '0;
    o_arr_b1 = '0;
    case (r_state)
      FEED0: begin
        o_arr_en = 1'b1;
        o_arr_a0 = r_a[IDX00*DW +: DW];
        o_arr_a1 = r_a[IDX10*DW +: DW];
        o_arr_b0 = r_b[IDX00*DW +: DW];
        o_arr_b1 = r_b[IDX01*DW +: DW];
      end
      FEED1: begin
        o_arr_en = 1'b1;
        o_arr_a0 = r_a[IDX01*DW +: DW];
        o_arr_a1 = r_a[IDX11*DW +: DW];
        o_arr_b0 = r_b[IDX10*DW +: DW];
        o_arr_b1 = r_b[IDX11*DW +: DW];
      end
      default: ;
    endcase
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_c_res     = r_c_res;

endmodule

// File: tb/tb_systolic_2x2_ctrl.sv
// Bench for systolic_2x2_ctrl: two controllers (PE_LAT=1 and PE_LAT=3), each
// driving a behavioural 2x2 output-stationary accumulator array; expected
// products come from a reference matrix multiply pushed into a scoreboard.
module tb_systolic_2x2_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [31:0] a_mat, b_mat;
  logic        out_ready;
  logic        sel;

  logic        in_ready1, en1, ov1, busy1;
  logic [7:0]  a0_1, a1_1, b0_1, b1_1;
  logic [63:0] cres1;
  logic        in_ready2, en2, ov2, busy2;
  logic [7:0]  a0_2, a1_2, b0_2, b1_2;
  logic [63:0] cres2;

  logic [15:0] acc1 [4];
  logic [15:0] acc2 [4];
  logic [15:0] dly1_2 [4];
  logic [15:0] dly2_2 [4];

  int en_cnt1, en_cnt2;
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  systolic_2x2_ctrl #(.DW(8), .CW(16), .PE_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .o_in_ready(in_ready1),
    .i_a_mat(a_mat), .i_b_mat(b_mat), .o_arr_en(en1),
    .o_arr_a0(a0_1), .o_arr_a1(a1_1), .o_arr_b0(b0_1), .o_arr_b1(b1_1),
    .i_arr_c00(acc1[0]), .i_arr_c01(acc1[1]), .i_arr_c10(acc1[2]), .i_arr_c11(acc1[3]),
    .o_out_valid(ov1), .i_out_ready(out_ready), .o_c_res(cres1), .o_busy(busy1)
  );

  systolic_2x2_ctrl #(.DW(8), .CW(16), .PE_LAT(3)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .o_in_ready(in_ready2),
    .i_a_mat(a_mat), .i_b_mat(b_mat), .o_arr_en(en2),
    .o_arr_a0(a0_2), .o_arr_a1(a1_2), .o_arr_b0(b0_2), .o_arr_b1(b1_2),
    .i_arr_c00(dly2_2[0]), .i_arr_c01(dly2_2[1]), .i_arr_c10(dly2_2[2]), .i_arr_c11(dly2_2[3]),
    .o_out_valid(ov2), .i_out_ready(out_ready), .o_c_res(cres2), .o_busy(busy2)
  );

  // Behavioural arrays: PE(i,j) accumulates a_i*b_j; the second array exposes
  // its accumulators through two extra register stages (PE_LAT=3).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        acc1[i]   <= '0;
        acc2[i]   <= '0;
        dly1_2[i] <= '0;
        dly2_2[i] <= '0;
      end
    end else begin
      if (en1) begin
        acc1[0] <= acc1[0] + 16'(a0_1) * 16'(b0_1);
        acc1[1] <= acc1[1] + 16'(a0_1) * 16'(b1_1);
        acc1[2] <= acc1[2] + 16'(a1_1) * 16'(b0_1);
        acc1[3] <= acc1[3] + 16'(a1_1) * 16'(b1_1);
      end
      if (en2) begin
        acc2[0] <= acc2[0] + 16'(a0_2) * 16'(b0_2);
        acc2[1] <= acc2[1] + 16'(a0_2) * 16'(b1_2);
        acc2[2] <= acc2[2] + 16'(a1_2) * 16'(b0_2);
        acc2[3] <= acc2[3] + 16'(a1_2) * 16'(b1_2);
      end
      for (int i = 0; i < 4; i++) begin
        dly1_2[i] <= acc2[i];
        dly2_2[i] <= dly1_2[i];
      end
    end
  end

  always @(posedge clk) begin
    if (en1) en_cnt1 <= en_cnt1 + 1;
    if (en2) en_cnt2 <= en_cnt2 + 1;
  end

  logic        w_rdy, w_ov, w_en, w_busy;
  logic [63:0] w_cres;
  assign w_rdy  = sel ? in_ready2 : in_ready1;
  assign w_ov   = sel ? ov2 : ov1;
  assign w_en   = sel ? en2 : en1;
  assign w_busy = sel ? busy2 : busy1;
  assign w_cres = sel ? cres2 : cres1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mm(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] x [4];
    logic [15:0] y [4];
    logic [15:0] c00, c01, c10, c11;
    for (int k = 0; k < 4; k++) begin
      x[k] = 16'(a[(3-k)*8 +: 8]);
      y[k] = 16'(b[(3-k)*8 +: 8]);
    end
    c00 = x[0]*y[0] + x[1]*y[2];
    c01 = x[0]*y[1] + x[1]*y[3];
    c10 = x[2]*y[0] + x[3]*y[2];
    c11 = x[2]*y[1] + x[3]*y[3];
    return {c00, c01, c10, c11};
  endfunction

  task automatic compare_pop(input string tag);
    logic [63:0] exp;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty, got %0h", tag, w_cres);
    end else begin
      exp = sb.pop_front();
      chk(tag, w_cres, exp);
    end
  endtask

  // Offers a job and runs it to DONE; with hold=0 it also retires the result.
  task automatic run_job(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic hold);
    int t, lat, en0;
    sel = s;
    #1;
    t = 0;
    while (!w_rdy && t < 20) begin @(posedge clk); #1; t++; end
    chk({tag, "_in_ready"}, 64'(w_rdy), 64'd1);
    a_mat = a; b_mat = b;
    in_valid[s] = 1'b1;
    en0 = s ? en_cnt2 : en_cnt1;
    sb.push_back(mm(a, b));
    @(posedge clk); #1;
    lat = 1;
    in_valid = '0;
    while (!w_ov && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, 64'(lat), s ? 64'd6 : 64'd4);
    chk({tag, "_en_cycles"}, 64'((s ? en_cnt2 : en_cnt1) - en0), 64'd2);
    chk({tag, "_rdy_in_done"}, 64'(w_rdy), 64'd0);
    if (!hold) begin
      compare_pop({tag, "_c_res"});
      @(posedge clk); #1;
      chk({tag, "_ov_after"}, 64'(w_ov), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b1; sel = 1'b0;
    a_mat = '0; b_mat = '0;
    en_cnt1 = 0; en_cnt2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_out_valid", 64'(ov1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_arr", {31'd0, en1, a0_1, a1_1, b0_1, b1_1}, 64'd0);
    chk("rst_c_res", cres1, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(1'b0, 32'h01020304, 32'h05060708, "basic", 1'b0);
    chk("basic_const", mm(32'h01020304, 32'h05060708), {16'd19, 16'd22, 16'd43, 16'd50});
    run_job(1'b0, 32'h01000001, 32'h090a0b0c, "b2b", 1'b0);
    run_job(1'b0, 32'hffffffff, 32'hffffffff, "wrap", 1'b0);
    run_job(1'b0, 32'h01000001, 32'h01000001, "ident", 1'b0);

    // Hold the result for 6 cycles while offering spurious jobs.
    out_ready = 1'b0;
    run_job(1'b0, 32'h02030405, 32'h06070809, "bp", 1'b1);
    for (int i = 0; i < 6; i++) begin
      a_mat = 32'h11111111; b_mat = 32'h22222222;
      in_valid[0] = (i % 2 == 0);
      @(posedge clk); #1;
      chk("bp_c_res_stable", cres1, sb[0]);
      chk("bp_in_ready", 64'(in_ready1), 64'd0);
      chk("bp_arr_en", 64'(en1), 64'd0);
      chk("bp_out_valid", 64'(ov1), 64'd1);
    end
    compare_pop("bp_c_res");
    // in_valid coincides with DONE->IDLE: must not be taken.
    in_valid[0] = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_exit_in_ready", 64'(in_ready1), 64'd1);
    chk("bp_exit_busy", 64'(busy1), 64'd0);
    chk("bp_exit_arr_en", 64'(en1), 64'd0);
    in_valid = '0;
    @(posedge clk); #1;

    // Reset during FEED1.
    sel = 1'b0;
    a_mat = 32'h05050505; b_mat = 32'h07070707;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid = '0;
    @(posedge clk); #1;
    chk("rstmid_in_feed1", 64'(en1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_arr", {31'd0, en1, a0_1, a1_1, b0_1, b1_1}, 64'd0);
    chk("rstmid_out_valid", 64'(ov1), 64'd0);
    chk("rstmid_busy", 64'(busy1), 64'd0);
    chk("rstmid_c_res", cres1, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_in_ready", 64'(in_ready1), 64'd1);
    run_job(1'b0, 32'h02000002, 32'h03040506, "after_rst", 1'b0);

    run_job(1'b1, 32'h01020304, 32'h05060708, "lat3", 1'b0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
